out_port_ctrl: RTL and testbench

//  Output-port stage between the processor datapath/control unit and the 7-segment

---
 rtl/out_port_ctrl.sv | 124 ++++++++++++
 tb/tb_out_port_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/out_port_ctrl.sv
// Output-port stage feeding the 7-segment decoder.
// Holds each displayed value for at least HOLD_CYCLES clocks. A one-entry
// pending buffer absorbs one early write. stall back-pressures the
// processor while that buffer is occupied during the hold time.
module out_port_ctrl #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        out_en,
    input  logic [31:0] out_data,
    input  logic        blank,
    output logic        stall,
    output logic        flagOUT,
    output logic [31:0] Value,
    output logic        pending
);

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_STEADY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       value_q, value_d;
    logic [31:0]       buf_q, buf_d;
    logic              flag_q, flag_d;
    logic              pend_q, pend_d;
    logic              stall_s;
    logic              accept_s;

    // A blank request discards the simultaneous write, so it never stalls.
    assign stall_s  = out_en & ~reset & ~blank & (state_q == ST_HOLD) & pend_q;
    assign accept_s = out_en & ~stall_s & ~blank;

    assign stall   = stall_s;
    assign flagOUT = flag_q;
    assign Value   = value_q;
    assign pending = pend_q;

    // Next-state and next-output computation for the display FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        buf_d   = buf_q;
        flag_d  = flag_q;
        pend_d  = pend_q;
        if (blank) begin
            // Value is kept; only the enable and buffered entry are dropped.
            state_d = ST_BLANK;
            flag_d  = 1'b0;
            pend_d  = 1'b0;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_BLANK, ST_STEADY: begin
                    if (accept_s) begin
                        value_d = out_data;
                        flag_d  = 1'b1;
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                        // Accept here implies the buffer is free.
                        if (accept_s) begin
                            buf_d  = out_data;
                            pend_d = 1'b1;
                        end else begin
                            pend_d = pend_q;
                        end
                    end else if (pend_q) begin
                        value_d = buf_q;
                        cnt_d   = CNT_RELOAD;
                        pend_d  = 1'b0;
                    end else if (accept_s) begin
                        value_d = out_data;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        state_d = ST_STEADY;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    flag_d  = 1'b0;
                    pend_d  = 1'b0;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= CNT_ZERO;
            value_q <= 32'd0;
            buf_q   <= 32'd0;
            flag_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            buf_q   <= buf_d;
            flag_q  <= flag_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_out_port_ctrl.sv
// Self-checking bench for out_port_ctrl with HOLD_CYCLES=4.
// Reference model tracks how long the current value has been on display and
// a queue of waiting writes, and is compared against the DUT every cycle.
module tb_out_port_ctrl;

    localparam int HOLD = 4;

    logic        clock;
    logic        reset;
    logic        out_en;
    logic [31:0] out_data;
    logic        blank;
    logic        stall;
    logic        flagOUT;
    logic [31:0] Value;
    logic        pending;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // model state
    logic        m_on;
    logic [31:0] m_val;
    int          m_age;
    logic [31:0] m_q[$];
    logic        m_stall;

    out_port_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .out_en   (out_en),
        .out_data (out_data),
        .blank    (blank),
        .stall    (stall),
        .flagOUT  (flagOUT),
        .Value    (Value),
        .pending  (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: predict stall, check it, advance model, check outputs.
    task automatic step(input logic en, input logic [31:0] data, input logic blk, input logic rst);
        logic acc;
        logic expired;
        @(negedge clock);
        out_en   = en;
        out_data = data;
        blank    = blk;
        reset    = rst;
        #1;
        m_stall = en && !rst && !blk && m_on && (m_q.size() == 1);
        check_val("stall", {31'd0, stall}, {31'd0, m_stall});
        @(posedge clock);
        if (rst) begin
            m_on = 1'b0; m_val = 32'd0; m_age = HOLD; m_q.delete();
        end else if (blk) begin
            m_on = 1'b0; m_q.delete();
        end else begin
            acc     = en && !m_stall;
            expired = !m_on || (m_age >= HOLD - 1);
            if (!expired) begin
                m_age = m_age + 1;
                if (acc) m_q.push_back(data);
            end else if (m_q.size() != 0) begin
                m_val = m_q.pop_front();
                m_age = 0;
            end else if (acc) begin
                m_val = data; m_on = 1'b1; m_age = 0;
            end else if (m_age < HOLD) begin
                m_age = m_age + 1;
            end
        end
        #1;
        check_val("flagOUT", {31'd0, flagOUT}, {31'd0, m_on});
        check_val("Value",   Value, m_val);
        check_val("pending", {31'd0, pending}, {31'd0, (m_q.size() != 0)});
    endtask

    // Present a write and keep it asserted while stalled (bounded).
    task automatic write_val(input logic [31:0] data);
        int tries;
        tries = 0;
        step(1'b1, data, 1'b0, 1'b0);
        while (m_stall && tries < 20) begin
            step(1'b1, data, 1'b0, 1'b0);
            tries = tries + 1;
        end
        if (tries >= 20) check_val("stall_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        m_on = 1'b0; m_val = 32'd0; m_age = HOLD;
        out_en = 1'b0; out_data = 32'd0; blank = 1'b0; reset = 1'b1;

        // 1 reset with out_en asserted
        for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check_val("rst_value", Value, 32'd0);

        // 2 single write then expiry into steady display
        write_val(32'd123);
        check_val("single_val", Value, 32'd123);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        check_val("single_steady", Value, 32'd123);

        // 3 back-to-back writes 7, 8, 9
        write_val(32'd7);
        check_val("b2b_first", Value, 32'd7);
        write_val(32'd8);
        write_val(32'd9);
        check_val("b2b_second", Value, 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        check_val("b2b_third", Value, 32'd9);

        // 4 write on the expiry cycle loads directly
        write_val(32'd5);
        for (int i = 0; i < HOLD - 1; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        write_val(32'd6);
        check_val("edge_val", Value, 32'd6);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

        // 5 blank mid-hold with pending entry and simultaneous write
        write_val(32'd11);
        write_val(32'd12);
        step(1'b1, 32'd13, 1'b1, 1'b0);
        check_val("blank_flag", {31'd0, flagOUT}, 32'd0);
        check_val("blank_keep", Value, 32'd11);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        write_val(32'd14);
        check_val("blank_reenable", Value, 32'd14);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

        // 6 negative value passes through untouched
        write_val(32'hFFFF_FE0C);
        check_val("neg_val", Value, 32'hFFFF_FE0C);

        // reset mid-hold with pending entry
        write_val(32'd21);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        check_val("rst_mid", Value, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) == 1), $urandom(),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
